// File: rtl/mesh_out_port_arbiter.sv
// Round-robin arbiter for one mesh router output port: grants one single-word
// packet at a time, pops the winning input FIFO and pushes the word downstream.
module mesh_out_port_arbiter #(
    parameter int pckg_sz = 40,
    parameter int N_IN    = 5,
    parameter int CNT_W   = 16,
    localparam int PTR_W  = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN-1:0]         req,
    input  logic [N_IN*pckg_sz-1:0] data_in,
    input  logic                    full_out,
    output logic [N_IN-1:0]         pop,
    output logic                    push_out,
    output logic [pckg_sz-1:0]      data_out,
    output logic [PTR_W-1:0]        gnt_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W:0]      scan_idx;
    logic                win_found;
    logic [pckg_sz-1:0]  win_data;

    logic [N_IN-1:0]     pop_nxt;
    logic                push_nxt;
    logic                busy_nxt;
    logic [pckg_sz-1:0]  data_nxt;
    logic [PTR_W-1:0]    gnt_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // Rotating priority scan: first requester at or after rr_ptr, modulo N_IN.
    // NOTE: combinational blocks use blocking (=) assignments so later statements see earlier results.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_IN; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(N_IN))
                scan_idx = scan_idx - (PTR_W+1)'(N_IN);
            if (!win_found && req[scan_idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (win_idx == PTR_W'(i))
                win_data = data_in[i*pckg_sz +: pckg_sz];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        pop_nxt    = '0;
        push_nxt   = 1'b0;
        busy_nxt   = 1'b0;
        data_nxt   = data_out;
        gnt_nxt    = gnt_id;
        cnt_nxt    = pkt_cnt;

        case (state)
            IDLE: begin
                if (win_found && !full_out) begin
                    pop_nxt          = '0;
                    pop_nxt[win_idx] = 1'b1;
                    push_nxt         = 1'b1;
                    busy_nxt         = 1'b1;
                    data_nxt         = win_data;
                    gnt_nxt          = win_idx;
                    cnt_nxt          = pkt_cnt + 1'b1;
                    rr_ptr_nxt       = (win_idx == PTR_W'(N_IN-1)) ? '0 : win_idx + 1'b1;
                    state_nxt        = XFER;
                end
            end
            // The input's pndng flag is stale until the pop lands, so req is not looked at here.
            XFER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            pop      <= '0;
            push_out <= 1'b0;
            busy     <= 1'b0;
            data_out <= '0;
            gnt_id   <= '0;
            pkt_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            pop      <= pop_nxt;
            push_out <= push_nxt;
            busy     <= busy_nxt;
            data_out <= data_nxt;
            gnt_id   <= gnt_nxt;
            pkt_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mesh_out_port_arbiter.sv
// Directed bench for mesh_out_port_arbiter: reset, single grant, fairness,
// backpressure, rotation wrap, counter wrap and reset during XFER.
module tb_mesh_out_port_arbiter;

    localparam int PW    = 40;
    localparam int N_IN  = 5;
    // Narrow counter so the wrap is reached in a handful of grants.
    localparam int CNT_W = 4;

    logic                  clk;
    logic                  reset;
    logic [N_IN-1:0]       req;
    logic [N_IN*PW-1:0]    data_in;
    logic                  full_out;
    logic [N_IN-1:0]       pop;
    logic                  push_out;
    logic [PW-1:0]         data_out;
    logic [2:0]            gnt_id;
    logic                  busy;
    logic [CNT_W-1:0]      pkt_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] exp_cnt;

    mesh_out_port_arbiter #(.pckg_sz(PW), .N_IN(N_IN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .full_out (full_out),
        .pop      (pop),
        .push_out (push_out),
        .data_out (data_out),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [N_IN-1:0] e_pop, input logic e_push,
                              input logic e_busy, input logic [2:0] e_gnt, input logic [PW-1:0] e_data,
                              input logic [CNT_W-1:0] e_cnt);
        check({tag, ".pop"},  64'(pop),      64'(e_pop));
        check({tag, ".push"}, 64'(push_out), 64'(e_push));
        check({tag, ".busy"}, 64'(busy),     64'(e_busy));
        check({tag, ".gnt"},  64'(gnt_id),   64'(e_gnt));
        check({tag, ".data"}, 64'(data_out), 64'(e_data));
        check({tag, ".cnt"},  64'(pkt_cnt),  64'(e_cnt));
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] dval(input int i);
        logic [PW-1:0] base;
        base = 40'hC0_0000_0000;
        return base + PW'(i * 16'h0111);
    endfunction

    task automatic load_table();
        for (int i = 0; i < N_IN; i++)
            data_in[i*PW +: PW] = dval(i);
    endtask

    initial begin
        logic [N_IN-1:0] e_pop;
        reset    = 1'b1;
        req      = 5'h1F;
        full_out = 1'b0;
        data_in  = '0;
        load_table();
        exp_cnt  = '0;

        // Reset held 3 clocks with every input requesting
        for (int c = 0; c < 3; c++) begin
            step();
            check_outs("reset", '0, 1'b0, 1'b0, 3'd0, '0, '0);
        end

        // Single request on input 2
        reset = 1'b0;
        req   = 5'b00100;
        data_in[2*PW +: PW] = 40'hA5_0000_1234;
        step();
        exp_cnt = exp_cnt + 1'b1;
        check_outs("single.gnt", 5'b00100, 1'b1, 1'b1, 3'd2, 40'hA5_0000_1234, exp_cnt);
        req = '0;
        data_in[2*PW +: PW] = 40'hFF_FFFF_FFFF;
        step();
        check_outs("single.end", '0, 1'b0, 1'b0, 3'd2, 40'hA5_0000_1234, exp_cnt);

        // Fairness from reset release with all inputs requesting
        load_table();
        reset = 1'b1;
        step();
        check_outs("rst_idle", '0, 1'b0, 1'b0, 3'd0, '0, '0);
        exp_cnt = '0;
        reset = 1'b0;
        req   = 5'h1F;
        for (int g = 0; g < 6; g++) begin
            step();
            exp_cnt = exp_cnt + 1'b1;
            e_pop = 5'b00001 << (g % N_IN);
            check_outs($sformatf("fair.g%0d", g), e_pop, 1'b1, 1'b1, 3'(g % N_IN), dval(g % N_IN), exp_cnt);
            step();
            check_outs($sformatf("fair.x%0d", g), '0, 1'b0, 1'b0, 3'(g % N_IN), dval(g % N_IN), exp_cnt);
        end

        // Backpressure: input 1 waits while the output FIFO is full
        req      = 5'b00010;
        full_out = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check_outs($sformatf("bp.hold%0d", c), '0, 1'b0, 1'b0, 3'd0, dval(0), exp_cnt);
        end
        full_out = 1'b0;
        step();
        exp_cnt = exp_cnt + 1'b1;
        check_outs("bp.gnt", 5'b00010, 1'b1, 1'b1, 3'd1, dval(1), exp_cnt);
        req = '0;
        step();
        check_outs("bp.end", '0, 1'b0, 1'b0, 3'd1, dval(1), exp_cnt);

        // Rotation wrap: grant input 3 (rr_ptr -> 4), then 10001 serves 4 before 0
        req = 5'b01000;
        step();
        exp_cnt = exp_cnt + 1'b1;
        check_outs("rot.g3", 5'b01000, 1'b1, 1'b1, 3'd3, dval(3), exp_cnt);
        req = 5'b10001;
        step();
        check_outs("rot.x3", '0, 1'b0, 1'b0, 3'd3, dval(3), exp_cnt);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check_outs("rot.g4", 5'b10000, 1'b1, 1'b1, 3'd4, dval(4), exp_cnt);
        // full_out rising during XFER does not retract the committed push
        full_out = 1'b1;
        step();
        check_outs("rot.x4", '0, 1'b0, 1'b0, 3'd4, dval(4), exp_cnt);
        full_out = 1'b0;
        step();
        exp_cnt = exp_cnt + 1'b1;
        check_outs("rot.g0", 5'b00001, 1'b1, 1'b1, 3'd0, dval(0), exp_cnt);
        req = '0;
        step();
        check_outs("rot.x0", '0, 1'b0, 1'b0, 3'd0, dval(0), exp_cnt);

        // Counter wrap: keep granting input 0 past all-ones
        req = 5'b00001;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_cnt = exp_cnt + 1'b1;
            check_outs($sformatf("wrap.g%0d", k), 5'b00001, 1'b1, 1'b1, 3'd0, dval(0), exp_cnt);
            step();
        end
        check("wrap.zero", 64'(pkt_cnt), 64'd0);

        // Reset pulse in the middle of an XFER
        step();
        check_outs("mid.gnt", 5'b00001, 1'b1, 1'b1, 3'd0, dval(0), 4'd1);
        reset = 1'b1;
        req   = '0;
        step();
        check_outs("mid.rst", '0, 1'b0, 1'b0, 3'd0, '0, '0);
        // rr_ptr is back to 0, so input 0 wins over input 4
        reset = 1'b0;
        req   = 5'b10001;
        step();
        check_outs("mid.after", 5'b00001, 1'b1, 1'b1, 3'd0, dval(0), 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
